rpc_mc: RTL

Multi-channel successor to the single-flow RPC serializer/deserializer. It arbitrates RPCs from N_CHANNELS CPU endpoints onto one network TX stream and serializes each into a NetworkPacketInternal. It steers RX packets back to the endpoint selected by conn_id. Unlike the previous block it has valid/ready backpressure on every interface, per-channel buffering, oversize-RPC drop and saturating statistics counters.

---
 rtl/rpc_mc_pkg.sv | 51 +++++
 rtl/rpc_mc_rr_arbiter.sv | 45 ++++
 rtl/rpc_mc.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rpc_mc_pkg.sv
// Shared RPC / network packet types and the packet (de)serialization helpers
// used by the multi-channel RPC block.
package rpc_mc_pkg;

    typedef struct packed {
        logic [15:0] argl;
        logic [15:0] fn_id;
        logic [31:0] req_id;
    } RpcHeader;

    typedef struct packed {
        RpcHeader     hdr;
        logic [127:0] args;
    } RpcPckt;

    typedef struct packed {
        logic [15:0] flow_id;
        RpcPckt      rpc_data;
    } RpcIf;

    typedef struct packed {
        logic [15:0] payload_size;
        logic [15:0] conn_id;
        logic [31:0] flags;
    } NetHeader;

    typedef struct packed {
        NetHeader     hdr;
        logic [255:0] payload;
    } NetworkPacketInternal;

    localparam int RPC_HDR_BYTES = $bits(RpcHeader) >> 3;
    localparam int PCKT_W        = $bits(RpcPckt);

    function automatic NetworkPacketInternal rpc_serialize(input RpcIf r);
        NetworkPacketInternal p;
        p                   = '0;
        p.hdr.payload_size  = 16'(RPC_HDR_BYTES) + r.rpc_data.hdr.argl;
        p.hdr.conn_id       = r.flow_id;
        p.payload[PCKT_W-1:0] = r.rpc_data;
        return p;
    endfunction

    function automatic RpcIf rpc_deserialize(input NetworkPacketInternal p);
        RpcIf r;
        r.flow_id  = p.hdr.conn_id;
        r.rpc_data = RpcPckt'(p.payload[PCKT_W-1:0]);
        return r;
    endfunction

endpackage

// File: rtl/rpc_mc_rr_arbiter.sv
// Round-robin arbiter: priority starts at rr_ptr and wraps; the pointer moves
// past the winner only when the grant is consumed (advance).
module rpc_mc_rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any
);

    logic [W-1:0] rr_ptr;
    logic [W-1:0] idx;

    // N is a power of two, so W-bit addition wraps modulo N for free.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = rr_ptr + W'(i);
            if (!any && req[idx]) begin
                any       = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        grant            = '0;
        grant[grant_idx] = any;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else if (advance && any)
            rr_ptr <= grant_idx + 1'b1;
    end

endmodule

// File: rtl/rpc_mc.sv
// Multi-channel RPC serializer/deserializer: round-robin arbitration of
// per-channel TX holds onto one network stream, conn_id-steered RX delivery.
module rpc_mc
    import rpc_mc_pkg::*;
#(
    parameter logic [31:0] NIC_ID     = 32'h0,
    parameter int          N_CHANNELS = 4,
    parameter int          MAX_ARGL   = 64,
    parameter int          CNT_W      = 32,
    localparam int         CH_W       = $clog2(N_CHANNELS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CHANNELS-1:0]        rpc_valid_in,
    input  RpcIf [N_CHANNELS-1:0]        rpc_in,
    output logic [N_CHANNELS-1:0]        rpc_ready_out,
    output NetworkPacketInternal         network_tx_out,
    output logic                         network_tx_valid_out,
    input  logic                         network_tx_ready_in,
    input  NetworkPacketInternal         network_rx_in,
    input  logic                         network_rx_valid_in,
    output logic                         network_rx_ready_out,
    output logic [N_CHANNELS-1:0]        rpc_valid_out,
    output RpcIf [N_CHANNELS-1:0]        rpc_out,
    input  logic [N_CHANNELS-1:0]        rpc_ready_in,
    output logic [CNT_W-1:0]             tx_cnt,
    output logic [CNT_W-1:0]             rx_cnt,
    output logic [CNT_W-1:0]             drop_cnt
);

    // NIC_ID only tags simulation messages; nothing in the datapath uses it.
    localparam logic [31:0] NIC_TAG_UNUSED = NIC_ID;
    localparam logic [15:0] MAX_ARGL_W     = 16'(MAX_ARGL);

    logic [N_CHANNELS-1:0] hold_v;
    RpcIf [N_CHANNELS-1:0] hold_q;
    logic [N_CHANNELS-1:0] grant;
    logic [CH_W-1:0]       grant_idx;
    logic                  grant_any;
    logic                  slot_free;
    logic                  drop;
    logic                  tx_load;
    logic                  tx_xfer;
    logic [CH_W-1:0]       rx_ch;
    logic                  rx_acc;

    assign slot_free = !network_tx_valid_out || network_tx_ready_in;
    assign tx_xfer   = network_tx_valid_out && network_tx_ready_in;

    rpc_mc_rr_arbiter #(.N(N_CHANNELS), .W(CH_W)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (hold_v),
        .advance   (slot_free),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // An oversize winner still consumes its grant; it just never reaches the wire.
    assign drop    = slot_free && grant_any && (hold_q[grant_idx].rpc_data.hdr.argl > MAX_ARGL_W);
    assign tx_load = slot_free && grant_any && !drop;

    assign rpc_ready_out = ~hold_v | (grant & {N_CHANNELS{slot_free}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_v <= '0;
            hold_q <= '0;
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (rpc_valid_in[i] && rpc_ready_out[i]) begin
                    hold_v[i] <= 1'b1;
                    hold_q[i] <= rpc_in[i];
                end else if (grant[i] && slot_free) begin
                    hold_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            network_tx_valid_out <= 1'b0;
            network_tx_out       <= '0;
        end else if (slot_free) begin
            network_tx_valid_out <= tx_load;
            if (tx_load)
                network_tx_out <= rpc_serialize(hold_q[grant_idx]);
        end
    end

    // RX is head-of-line: a busy target channel back-pressures the whole stream.
    assign rx_ch                = network_rx_in.hdr.conn_id[CH_W-1:0];
    assign network_rx_ready_out = !rpc_valid_out[rx_ch] || rpc_ready_in[rx_ch];
    assign rx_acc               = network_rx_valid_in && network_rx_ready_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpc_valid_out <= '0;
            rpc_out       <= '0;
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (rx_acc && rx_ch == CH_W'(i)) begin
                    rpc_valid_out[i] <= 1'b1;
                    rpc_out[i]       <= rpc_deserialize(network_rx_in);
                end else if (rpc_ready_in[i]) begin
                    rpc_valid_out[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (tx_xfer && tx_cnt != '1)
                tx_cnt <= tx_cnt + 1'b1;
            if (rx_acc && rx_cnt != '1)
                rx_cnt <= rx_cnt + 1'b1;
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
